pixel_reader: RTL and testbench

Reads one 8-bit pixel from the 256x192 8bpp video frame buffer in LPDDR through a read-only MCB user port. It is the counterpart of `pixel_writer`, which writes pixels over port 4. The processor and the sprite/collision logic use it to service pixel read requests. It sits beside `vga_display` on the memory's command and read-FIFO interface; it issues single-word reads and returns the addressed byte with a done pulse.

---
 rtl/consolite_mem_pkg.sv | 29 ++
 rtl/pixel_reader.sv | 166 ++++++++++++++++
 tb/tb_pixel_reader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/consolite_mem_pkg.sv
// Shared LPDDR / video frame buffer definitions for the consolite memory clients.
// Provides MCB command codes, screen geometry, the frame buffer base address
// and the pixel_reader state encoding.
package consolite_mem_pkg;

   localparam logic [2:0]  MCB_WRITE = 3'b000;
   localparam logic [2:0]  MCB_READ  = 3'b001;

   localparam int unsigned SCREEN_W  = 256;
   localparam int unsigned SCREEN_H  = 192;

   localparam logic [29:0] VRAM_BASE = 30'd0;

   localparam int unsigned TIMER_W   = 10;

   typedef enum logic [2:0] {
      PR_DRAIN = 3'd0,
      PR_IDLE  = 3'd1,
      PR_CMD   = 3'd2,
      PR_WAIT  = 3'd3,
      PR_POP   = 3'd4
   } pixel_rd_state_t;

   // Word-aligned frame buffer offset of pixel (x,y): {y,x} with lane bits cleared.
   function automatic logic [29:0] pixel_word_offset(input logic [7:0] x, input logic [7:0] y);
      return 30'({y, x[7:2], 2'b00});
   endfunction

endpackage

// File: rtl/pixel_reader.sv
// pixel_reader: fetches one 8bpp pixel from the LPDDR frame buffer through a
// read-only MCB user port and returns the addressed byte with a done pulse.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   pixel_en/x/y            - request strobe and pixel coordinates
//   pixel_rgb/rd_done/rd_err- returned byte, done pulse, abort flag
//   pixel_busy              - request in progress or read FIFO draining
//   mem_cmd_*               - MCB command FIFO (single-word reads)
//   mem_rd_*                - MCB read data FIFO (first-word fall-through)
module pixel_reader
   import consolite_mem_pkg::*;
#(
   parameter logic [29:0] BASE_ADDR = 30'd0,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pixel_en,
   input  logic [7:0]  pixel_x,
   input  logic [7:0]  pixel_y,
   output logic [7:0]  pixel_rgb,
   output logic        pixel_rd_done,
   output logic        pixel_rd_err,
   output logic        pixel_busy,
   output logic        mem_cmd_en,
   output logic [2:0]  mem_cmd_instr,
   output logic [5:0]  mem_cmd_bl,
   output logic [29:0] mem_cmd_byte_addr,
   input  logic        mem_cmd_empty,
   input  logic        mem_cmd_full,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rd_data,
   input  logic        mem_rd_empty,
   input  logic        mem_rd_full,
   input  logic [6:0]  mem_rd_count,
   input  logic        mem_rd_overflow,
   input  logic        mem_rd_error
);

   pixel_rd_state_t     state_q, state_d;
   logic [1:0]          lane_q, lane_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [29:0]         addr_q, addr_d;
   logic [7:0]          rgb_q, rgb_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                cmd_en_q, cmd_en_d;
   logic                rd_en_q, rd_en_d;
   logic [7:0]          lane_byte_c;
   logic                unused_c;

   assign unused_c = ^{mem_cmd_empty, mem_rd_full, mem_rd_count};

   // Little-endian byte lane select from the head word of the read FIFO.
   always_comb begin
      lane_byte_c = mem_rd_data[7:0];
      case (lane_q)
         2'd0:    lane_byte_c = mem_rd_data[7:0];
         2'd1:    lane_byte_c = mem_rd_data[15:8];
         2'd2:    lane_byte_c = mem_rd_data[23:16];
         default: lane_byte_c = mem_rd_data[31:24];
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      timer_d  = '0;
      addr_d   = addr_q;
      rgb_d    = rgb_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cmd_en_d = 1'b0;
      rd_en_d  = 1'b0;

      case (state_q)
         PR_DRAIN: begin
            rd_en_d = !mem_rd_empty;
            if (mem_rd_empty) state_d = PR_IDLE;
         end
         PR_IDLE: begin
            if (pixel_en) begin
               if (pixel_y >= 8'(SCREEN_H)) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
                  rgb_d  = 8'd0;
               end else begin
                  lane_d   = pixel_x[1:0];
                  addr_d   = BASE_ADDR + pixel_word_offset(pixel_x, pixel_y);
                  cmd_en_d = !mem_cmd_full;
                  state_d  = PR_CMD;
               end
            end
         end
         PR_CMD: begin
            // A registered push already went out this cycle; otherwise retry once space appears.
            if (cmd_en_q) state_d = PR_WAIT;
            else          cmd_en_d = !mem_cmd_full;
         end
         PR_WAIT: begin
            timer_d = timer_q + TIMER_W'(1);
            // FIFO errors beat arriving data; data beats the timeout.
            if (mem_rd_error || mem_rd_overflow ||
                (mem_rd_empty && (timer_q == TIMER_W'(TIMEOUT - 1)))) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               rgb_d   = 8'd0;
               state_d = PR_DRAIN;
            end else if (!mem_rd_empty) begin
               rd_en_d = 1'b1;
               done_d  = 1'b1;
               rgb_d   = lane_byte_c;
               state_d = PR_POP;
            end
         end
         PR_POP: begin
            state_d = PR_IDLE;
         end
         default: begin
            state_d = PR_DRAIN;
         end
      endcase

      busy_d = (state_d != PR_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= PR_DRAIN;
         lane_q   <= 2'd0;
         timer_q  <= '0;
         addr_q   <= BASE_ADDR;
         rgb_q    <= 8'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b1;
         cmd_en_q <= 1'b0;
         rd_en_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         timer_q  <= timer_d;
         addr_q   <= addr_d;
         rgb_q    <= rgb_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         cmd_en_q <= cmd_en_d;
         rd_en_q  <= rd_en_d;
      end
   end

   assign pixel_rgb         = rgb_q;
   assign pixel_rd_done     = done_q;
   assign pixel_rd_err      = err_q;
   assign pixel_busy        = busy_q;
   assign mem_cmd_en        = cmd_en_q;
   assign mem_cmd_instr     = MCB_READ;
   assign mem_cmd_bl        = 6'd0;
   assign mem_cmd_byte_addr = addr_q;
   assign mem_rd_en         = rd_en_q;

endmodule

// File: tb/tb_pixel_reader.sv
// Directed bench for pixel_reader: drain after reset, in-range reads on
// several byte lanes, out-of-range rejection, command back-pressure,
// timeout abort and FIFO-error abort.
module tb_pixel_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pixel_en;
   logic [7:0]  pixel_x, pixel_y;
   logic [7:0]  pixel_rgb;
   logic        pixel_rd_done, pixel_rd_err, pixel_busy;
   logic        mem_cmd_en;
   logic [2:0]  mem_cmd_instr;
   logic [5:0]  mem_cmd_bl;
   logic [29:0] mem_cmd_byte_addr;
   logic        mem_cmd_empty, mem_cmd_full;
   logic        mem_rd_en;
   logic [31:0] mem_rd_data;
   logic        mem_rd_empty, mem_rd_full;
   logic [6:0]  mem_rd_count;
   logic        mem_rd_overflow, mem_rd_error;

   int tests = 0;
   int fails = 0;
   int cmd_cnt = 0;
   int rd_cnt = 0;
   int cmd_base, rd_base;

   always #5 clk = ~clk;

   pixel_reader #(.BASE_ADDR(30'd0), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .pixel_en(pixel_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pixel_rgb(pixel_rgb), .pixel_rd_done(pixel_rd_done),
      .pixel_rd_err(pixel_rd_err), .pixel_busy(pixel_busy),
      .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr),
      .mem_cmd_bl(mem_cmd_bl), .mem_cmd_byte_addr(mem_cmd_byte_addr),
      .mem_cmd_empty(mem_cmd_empty), .mem_cmd_full(mem_cmd_full),
      .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .mem_rd_empty(mem_rd_empty), .mem_rd_full(mem_rd_full),
      .mem_rd_count(mem_rd_count), .mem_rd_overflow(mem_rd_overflow),
      .mem_rd_error(mem_rd_error)
   );

   // Pulse counters for the memory-side strobes (sampled pre-edge values).
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_cmd_en === 1'b1) cmd_cnt = cmd_cnt + 1;
         if (mem_rd_en === 1'b1)  rd_cnt  = rd_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // In-range read: request, command, `gap` empty WAIT cycles, then data.
   task automatic do_read(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [31:0] word, input int gap,
                          input logic [29:0] exp_addr, input logic [7:0] exp_rgb);
      cmd_base = cmd_cnt;
      rd_base  = rd_cnt;
      pixel_x = x; pixel_y = y; pixel_en = 1'b1;
      step();
      pixel_en = 1'b0;
      chk({tag, "_cmd_en"}, 32'(mem_cmd_en), 32'd1);
      chk({tag, "_addr"}, 32'(mem_cmd_byte_addr), 32'(exp_addr));
      step();
      chk({tag, "_cmd_en_off"}, 32'(mem_cmd_en), 32'd0);
      for (int i = 0; i < gap; i++) begin
         step();
         chk({tag, "_no_done"}, 32'(pixel_rd_done), 32'd0);
      end
      mem_rd_data = word; mem_rd_empty = 1'b0;
      step();
      chk({tag, "_done"}, 32'(pixel_rd_done), 32'd1);
      chk({tag, "_err"}, 32'(pixel_rd_err), 32'd0);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
      chk({tag, "_rgb"}, 32'(pixel_rgb), 32'(exp_rgb));
      mem_rd_empty = 1'b1;
      step();
      chk({tag, "_done_off"}, 32'(pixel_rd_done), 32'd0);
      chk({tag, "_idle"}, 32'(pixel_busy), 32'd0);
      chk({tag, "_rgb_hold"}, 32'(pixel_rgb), 32'(exp_rgb));
      chk({tag, "_one_cmd"}, 32'(cmd_cnt - cmd_base), 32'd1);
      chk({tag, "_one_pop"}, 32'(rd_cnt - rd_base), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; pixel_en = 1'b0; pixel_x = 8'd0; pixel_y = 8'd0;
      mem_cmd_empty = 1'b1; mem_cmd_full = 1'b0; mem_rd_data = 32'd0;
      mem_rd_empty = 1'b0; mem_rd_full = 1'b0; mem_rd_count = 7'd0;
      mem_rd_overflow = 1'b0; mem_rd_error = 1'b0;

      // Reset values, with stale data sitting in the read FIFO.
      step(); step();
      chk("rst_rgb", 32'(pixel_rgb), 32'd0);
      chk("rst_done", 32'(pixel_rd_done), 32'd0);
      chk("rst_err", 32'(pixel_rd_err), 32'd0);
      chk("rst_cmd_en", 32'(mem_cmd_en), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_addr", 32'(mem_cmd_byte_addr), 32'd0);
      chk("rst_busy", 32'(pixel_busy), 32'd1);
      chk("cmd_instr", 32'(mem_cmd_instr), 32'd1);
      chk("cmd_bl", 32'(mem_cmd_bl), 32'd0);

      // Drain: three stale words popped, then busy falls.
      rst_n = 1'b1;
      cmd_base = cmd_cnt; rd_base = rd_cnt;
      step();
      chk("drain_rd_en", 32'(mem_rd_en), 32'd1);
      chk("drain_busy", 32'(pixel_busy), 32'd1);
      step(); step();
      mem_rd_empty = 1'b1;
      step();
      chk("drain_done_busy", 32'(pixel_busy), 32'd0);
      chk("drain_pops", 32'(rd_cnt - rd_base), 32'd3);
      chk("drain_no_cmd", 32'(cmd_cnt - cmd_base), 32'd0);

      // (127,95): offset 0x5F7F -> word 0x5F7C, lane 3.
      do_read("mid", 8'd127, 8'd95, 32'hAABB_CCDD, 4, 30'h5F7C, 8'hAA);
      // Minimum latency reads, lanes 0 and 2 of word 0.
      do_read("lane0", 8'd0, 8'd0, 32'h1122_3344, 0, 30'h0, 8'h44);
      do_read("lane2", 8'd2, 8'd0, 32'h1122_3344, 0, 30'h0, 8'h22);

      // Out-of-range row: err done next cycle, no memory access.
      cmd_base = cmd_cnt;
      pixel_x = 8'd5; pixel_y = 8'd192; pixel_en = 1'b1;
      step();
      pixel_en = 1'b0;
      chk("oor_done", 32'(pixel_rd_done), 32'd1);
      chk("oor_err", 32'(pixel_rd_err), 32'd1);
      chk("oor_rgb", 32'(pixel_rgb), 32'd0);
      chk("oor_busy", 32'(pixel_busy), 32'd0);
      step();
      chk("oor_done_off", 32'(pixel_rd_done), 32'd0);
      chk("oor_no_cmd", 32'(cmd_cnt - cmd_base), 32'd0);

      // Command FIFO full for 4 cycles after acceptance; extra requests ignored.
      cmd_base = cmd_cnt;
      pixel_x = 8'd4; pixel_y = 8'd1; pixel_en = 1'b1; mem_cmd_full = 1'b1;
      step();
      pixel_x = 8'd200;
      chk("full_cmd_off0", 32'(mem_cmd_en), 32'd0);
      chk("full_busy", 32'(pixel_busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("full_cmd_off", 32'(mem_cmd_en), 32'd0);
      end
      mem_cmd_full = 1'b0; pixel_en = 1'b0;
      step();
      chk("full_cmd_on", 32'(mem_cmd_en), 32'd1);
      chk("full_addr", 32'(mem_cmd_byte_addr), 32'h104);
      step();
      chk("full_cmd_once", 32'(mem_cmd_en), 32'd0);
      mem_rd_data = 32'hDEAD_BEEF; mem_rd_empty = 1'b0;
      step();
      chk("full_done", 32'(pixel_rd_done), 32'd1);
      chk("full_rgb", 32'(pixel_rgb), 32'hEF);
      mem_rd_empty = 1'b1;
      step();
      chk("full_one_cmd", 32'(cmd_cnt - cmd_base), 32'd1);

      // Timeout: FIFO stays empty for 8 WAIT cycles.
      rd_base = rd_cnt;
      pixel_x = 8'd8; pixel_y = 8'd2; pixel_en = 1'b1;
      step();
      pixel_en = 1'b0;
      step();
      for (int i = 0; i < 7; i++) begin
         step();
         chk("to_no_done", 32'(pixel_rd_done), 32'd0);
      end
      step();
      chk("to_done", 32'(pixel_rd_done), 32'd1);
      chk("to_err", 32'(pixel_rd_err), 32'd1);
      chk("to_rgb", 32'(pixel_rgb), 32'd0);
      chk("to_busy", 32'(pixel_busy), 32'd1);
      step();
      chk("to_idle", 32'(pixel_busy), 32'd0);
      chk("to_no_pop", 32'(rd_cnt - rd_base), 32'd0);

      // FIFO error together with data: error wins, stale word drained.
      pixel_x = 8'd9; pixel_y = 8'd2; pixel_en = 1'b1;
      step();
      pixel_en = 1'b0;
      step();
      mem_rd_error = 1'b1; mem_rd_empty = 1'b0; mem_rd_data = 32'h5566_7788;
      step();
      mem_rd_error = 1'b0;
      chk("ferr_done", 32'(pixel_rd_done), 32'd1);
      chk("ferr_err", 32'(pixel_rd_err), 32'd1);
      chk("ferr_rgb", 32'(pixel_rgb), 32'd0);
      chk("ferr_no_pop", 32'(mem_rd_en), 32'd0);
      step();
      chk("ferr_drain_pop", 32'(mem_rd_en), 32'd1);
      chk("ferr_drain_busy", 32'(pixel_busy), 32'd1);
      mem_rd_empty = 1'b1;
      step();
      chk("ferr_idle", 32'(pixel_busy), 32'd0);
      chk("ferr_pop_off", 32'(mem_rd_en), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
